// File: rtl/cache_controller.sv
// Direct-mapped write-back, write-allocate cache controller with external data array.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 20,
  parameter int LINE_BITS  = 64
) (
  input  logic                           clk,
  input  logic                           gen_reset,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [TAG_BITS+INDEX_BITS-1:0] cpu_addr,
  input  logic [LINE_BITS-1:0]           cpu_wdata,
  output logic [LINE_BITS-1:0]           cpu_rdata,
  output logic                           cpu_ready,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0]           mem_wdata,
  input  logic                           mem_ack,
  input  logic [LINE_BITS-1:0]           mem_rdata,
  output logic                           arr_we,
  output logic                           arr_re,
  output logic [INDEX_BITS-1:0]          arr_addr,
  output logic [LINE_BITS-1:0]           arr_wdata,
  input  logic [LINE_BITS-1:0]           arr_rdata,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
);

  localparam int AW    = TAG_BITS + INDEX_BITS;
  localparam int LINES = 2 ** INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic                  we_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic [TAG_BITS-1:0]   tags_q [LINES];
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  capture;
  logic                  fill;
  logic                  mark_dirty;

  assign idx       = addr_q[INDEX_BITS-1:0];
  assign tag       = addr_q[AW-1:INDEX_BITS];
  assign hit       = valid_q[idx] && (tags_q[idx] == tag);
  assign cpu_rdata = rdata_q;

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    capture    = 1'b0;
    fill       = 1'b0;
    mark_dirty = 1'b0;
    cpu_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = '0;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_addr   = idx;
    arr_wdata  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          capture = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        arr_re = 1'b1;
        if (hit) begin
          if (we_q) begin
            arr_we     = 1'b1;
            mark_dirty = 1'b1;
          end else begin
            rdata_d = arr_rdata;
          end
          state_d = DONE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = REFILL;
        end
      end
      WRITEBACK: begin
        // Victim line streams straight from the array to memory.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tags_q[idx], idx};
        mem_wdata = arr_rdata;
        arr_re    = 1'b1;
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          arr_we = 1'b1;
          fill   = 1'b1;
          if (!we_q) begin
            arr_wdata = mem_rdata;
            rdata_d   = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (capture) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (mark_dirty) dirty_q[idx] <= 1'b1;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= we_q;
      end
    end
  end

  // Tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) tags_q[idx] <= tag;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
      if (!hit && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a transaction-level cache model.
// Expects statistics counters only when CACHE_STATS_EN is defined.
module tb_cache_controller;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        gen_reset;
  logic        cpu_req, cpu_we;
  logic [29:0] cpu_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        arr_we, arr_re;
  logic [9:0]  arr_addr;
  logic [63:0] arr_wdata, arr_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .gen_reset(gen_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .arr_we(arr_we), .arr_re(arr_re),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // External data array
  logic [63:0] darr [0:1023];
  always @(posedge clk) if (arr_we) darr[arr_addr] <= arr_wdata;
  assign arr_rdata = arr_re ? darr[arr_addr] : 64'h0;

  typedef struct {
    logic rdy, mreq, mwe, are, are_dc, awe, chk_rd;
    logic [29:0] maddr;
    logic [63:0] mwd, awd, rd;
    logic [9:0]  aaddr;
  } rec_t;

  rec_t expq[$];
  int tests = 0;
  int fails = 0;

  // Model: backing memory, dirty-line values, cache directory
  logic [63:0] mem  [logic [29:0]];
  logic [63:0] arch [logic [29:0]];
  logic [19:0] ctag [0:1023];
  bit          cval [0:1023];
  bit          cdirty [0:1023];
  int unsigned hits = 0;
  int unsigned misses = 0;
  logic [29:0] last_wb_addr = '0;
  logic [29:0] last_rf_addr = '0;
  logic [63:0] last_wb_data = '0;

  function automatic logic [63:0] memval(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, a, 4'h5};
  endfunction

  function automatic logic [63:0] val(input logic [29:0] a);
    if (arch.exists(a)) return arch[a];
    return memval(a);
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r = '{default: '0};
    return r;
  endfunction

  always @(negedge clk) begin
    rec_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("cpu_ready", 64'(cpu_ready), 64'(e.rdy));
      chk("mem_req", 64'(mem_req), 64'(e.mreq));
      chk("arr_we", 64'(arr_we), 64'(e.awe));
      if (!e.are_dc) chk("arr_re", 64'(arr_re), 64'(e.are));
      if (e.mreq) begin
        chk("mem_we", 64'(mem_we), 64'(e.mwe));
        chk("mem_addr", 64'(mem_addr), 64'(e.maddr));
        if (e.mwe) begin
          chk("mem_wdata", mem_wdata, e.mwd);
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          last_rf_addr = mem_addr;
        end
      end
      if (e.are || e.awe) chk("arr_addr", 64'(arr_addr), 64'(e.aaddr));
      if (e.awe) chk("arr_wdata", arr_wdata, e.awd);
      if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rd);
    end else begin
      chk("idle_mem_req", 64'(mem_req), 64'h0);
      chk("idle_ready", 64'(cpu_ready), 64'h0);
      chk("idle_arr_we", 64'(arr_we), 64'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garble(input bit hold);
    if (hold) begin
      cpu_addr  = 30'($urandom);
      cpu_we    = 1'($urandom);
      cpu_wdata = {$urandom, $urandom};
    end else begin
      cpu_req = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      cval[i]   = 1'b0;
      cdirty[i] = 1'b0;
    end
    arch.delete();
    hits   = 0;
    misses = 0;
  endtask

  task automatic chk_counters();
    chk("hit_count", 64'(hit_count), 64'(STATS ? hits : 0));
    chk("miss_count", 64'(miss_count), 64'(STATS ? misses : 0));
  endtask

  // One CPU transaction; called at posedge+1 of an IDLE cycle.
  task automatic txn(input logic [29:0] a, input logic w,
                     input logic [63:0] wd, input int dwb,
                     input int drf, input bit hold, input int rst_at);
    logic [9:0]  idx;
    logic [19:0] tg;
    logic [29:0] olda;
    bit          hit, wb;
    rec_t        r;
    idx  = a[9:0];
    tg   = a[29:10];
    hit  = cval[idx] && (ctag[idx] == tg);
    wb   = !hit && cval[idx] && cdirty[idx];
    olda = {ctag[idx], idx};

    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
    expq.push_back(idle_rec());
    step();
    garble(hold);
    r = idle_rec();
    r.are = 1'b1; r.aaddr = idx;
    r.awe = hit && w; r.awd = wd;
    expq.push_back(r);
    if (hit) begin
      if (hits != 32'hFFFF_FFFF) hits++;
      if (w) begin
        arch[a]     = wd;
        cdirty[idx] = 1'b1;
      end
    end else if (misses != 32'hFFFF_FFFF) begin
      misses++;
    end
    step();
    garble(hold);
    if (!hit) begin
      if (wb) begin
        for (int k = 0; k <= dwb; k++) begin
          r = idle_rec();
          r.mreq = 1'b1; r.mwe = 1'b1; r.maddr = olda;
          r.mwd = val(olda); r.are = 1'b1; r.aaddr = idx;
          expq.push_back(r);
          mem_ack = (k == dwb);
          step();
          garble(hold);
        end
        mem_ack = 1'b0;
        mem[olda] = val(olda);
        arch.delete(olda);
      end
      for (int k = 0; k <= drf; k++) begin
        if (k == rst_at) begin
          cpu_req = 1'b0;
          expq.push_back(idle_rec());
          #2 gen_reset = 1'b1;
          #1 chk("rst_mem_req", 64'(mem_req), 64'h0);
          chk("rst_ready", 64'(cpu_ready), 64'h0);
          step();
          gen_reset = 1'b0;
          mem_ack   = 1'b1;
          mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          expq.push_back(idle_rec());
          step();
          mem_ack = 1'b0;
          expq.push_back(idle_rec());
          step();
          model_reset();
          chk_counters();
          return;
        end
        r = idle_rec();
        r.mreq = 1'b1; r.maddr = a; r.are_dc = 1'b1;
        r.awe = (k == drf); r.aaddr = idx;
        r.awd = w ? wd : memval(a);
        expq.push_back(r);
        mem_ack   = (k == drf);
        mem_rdata = memval(a);
        step();
        garble(hold);
      end
      mem_ack = 1'b0;
      if (w) arch[a] = wd;
      ctag[idx]   = tg;
      cval[idx]   = 1'b1;
      cdirty[idx] = w;
    end
    r = idle_rec();
    r.rdy = 1'b1; r.chk_rd = !w; r.rd = val(a);
    expq.push_back(r);
    step();
    cpu_req = 1'b0;
    chk_counters();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    int          rst;
    gen_reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    mem[30'h0_5003] = 64'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 64'(cpu_ready), 64'h0);
    chk("rst_cpu_rdata", cpu_rdata, 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_arr_re", 64'(arr_re), 64'h0);
    chk_counters();
    gen_reset = 1'b0;
    step();

    txn(30'h0_5003, 1'b0, 64'h0, 0, 2, 1'b0, -1);
    chk("d35_rdata", cpu_rdata, 64'hA5);
    chk("d35_miss", 64'(miss_count), 64'(STATS ? 1 : 0));
    chk("d35_refill_addr", 64'(last_rf_addr), 64'h0_5003);

    txn(30'h0_5003, 1'b0, 64'h0, 0, 0, 1'b0, -1);
    chk("d36_rdata", cpu_rdata, 64'hA5);
    chk("d36_hit", 64'(hit_count), 64'(STATS ? 1 : 0));

    txn(30'h0_5003, 1'b1, 64'h1234, 0, 0, 1'b0, -1);
    txn(30'h0_7003, 1'b0, 64'h0, 1, 1, 1'b0, -1);
    chk("d37_wb_addr", 64'(last_wb_addr), 64'h0_5003);
    chk("d37_wb_data", last_wb_data, 64'h1234);
    chk("d37_rf_addr", 64'(last_rf_addr), 64'h0_7003);
    chk("d37_rdata", cpu_rdata, 64'({30'h0_7003, 30'h0_7003, 4'h5}));

    txn(30'h0_9001, 1'b0, 64'h0, 0, 4, 1'b0, 1);
    repeat (2) begin
      expq.push_back(idle_rec());
      step();
    end
    txn(30'h0_7003, 1'b0, 64'h0, 0, 1, 1'b0, -1);
    chk("d38_miss_after_rst", 64'(miss_count), 64'(STATS ? 1 : 0));
    chk("d38_hit_after_rst", 64'(hit_count), 64'h0);

    txn(30'h0_b002, 1'b1, 64'hCAFE, 0, 2, 1'b1, -1);
    txn(30'h0_d002, 1'b0, 64'h0, 2, 1, 1'b1, -1);
    chk("d39_wb_data", last_wb_data, 64'hCAFE);

    for (int n = 0; n < 300; n++) begin
      a   = {20'(5 + 2 * $urandom_range(0, 3)), 10'($urandom_range(0, 3))};
      rst = ($urandom_range(0, 24) == 0) ? 0 : -1;
      txn(a, 1'($urandom), {$urandom, $urandom},
          $urandom_range(0, 3),
          (rst == 0) ? 2 : $urandom_range(0, 3),
          1'($urandom), rst);
      if ($urandom_range(0, 3) == 0) begin
        expq.push_back(idle_rec());
        step();
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
